truth_table_sequencer: RTL and testbench
========================================

TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

Interface
REQ-001 The block SHALL have parameter N_IN, default 3: number of inputs of the combinational function under test (legal range 1..4).
REQ-002 The block SHALL have parameter DWELL, default 4: clock cycles each input combination is held (legal range 1..255).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port start, input, 1 bit: requests a sweep; sampled only in IDLE.
REQ-006 The block SHALL have port expected, input, 2^N_IN bits: golden truth table; bit k is the expected output for input combination k.
REQ-007 The block SHALL have port dut_in, output, N_IN bits: combination driven to the function; bit 0 = A, bit 1 = B, bit 2 = C.
REQ-008 The block SHALL have port dut_out, input, 1 bit: function output F.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a sweep is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse at sweep end.
REQ-011 The block SHALL have port table_out, output, 2^N_IN bits: captured truth table.
REQ-012 The block SHALL have port mismatch, output, 1 bit: table_out differs from the latched expected table.
REQ-013 The block SHALL have port fail_idx, output, N_IN bits: lowest mismatching combination index; 0 when there is no mismatch.

Function
REQ-014 The FSM SHALL have states IDLE, DRIVE and DONE.
REQ-015 In IDLE with start=1, the next state SHALL be DRIVE with dut_in=0, dwell counter=0, table_out cleared and expected latched internally.
REQ-016 In DRIVE, the dwell counter SHALL increment each cycle; dut_in SHALL be held stable until the counter reaches DWELL-1.
REQ-017 In the DRIVE cycle where counter==DWELL-1, dut_out SHALL be written into table_out[dut_in].
REQ-018 In that same cycle, if dut_in < 2^N_IN-1, dut_in SHALL increment and the counter SHALL clear; otherwise the next state SHALL be DONE.
REQ-019 In DONE, done SHALL be 1 for exactly one cycle, mismatch and fail_idx SHALL be registered from the final table, and the next state SHALL be IDLE.
REQ-020 busy SHALL be 1 exactly while the state is DRIVE.
REQ-021 Latency: start sampled at edge t SHALL give busy high from t+1, done high in cycle t+1+2^N_IN*DWELL (t+33 with defaults), and busy low in that done cycle.
REQ-022 start while in DRIVE or DONE SHALL be ignored; a start held high SHALL launch a new sweep from the IDLE cycle that follows DONE.
REQ-023 Changes on expected during a sweep SHALL have no effect; only the value latched at start is used.
REQ-024 table_out, mismatch and fail_idx SHALL hold their values in IDLE until the next accepted start, which SHALL clear mismatch and fail_idx.
REQ-025 dut_in SHALL wrap to 0 on entering DONE and SHALL remain 0 in IDLE.
REQ-026 With DWELL=1, every DRIVE cycle SHALL be a sample cycle, giving 2^N_IN cycles in DRIVE.

Reset
REQ-027 When rst_n=0 at a clock edge, the block SHALL enter IDLE and clear dut_in, the dwell counter, busy, done, table_out, mismatch and fail_idx to 0, in any state.
REQ-028 Reset during DRIVE SHALL abort the sweep with no done pulse.
REQ-029 A start sampled together with rst_n=0 SHALL be ignored.

Verification
REQ-030 Bench SHALL run a full sweep: model F=(A&B)|C, expected=8'hF8, defaults, start pulse -> dut_in steps 0..7 every 4 cycles; done at t+33; table_out=8'hF8; mismatch=0; fail_idx=0.
REQ-031 Bench SHALL check mismatch detection: same model with expected=8'hF0 -> table_out=8'hF8; mismatch=1; fail_idx=3.
REQ-032 Bench SHALL check reset mid-sweep: rst_n low for 1 cycle at t+10 -> next cycle busy=0, dut_in=0, table_out=0; no done pulse.
REQ-033 Bench SHALL check start during busy: extra start pulses at t+5 and t+20 -> exactly one done pulse, at t+33.
REQ-034 Bench SHALL check DWELL=1 with N_IN=2 and model F=A^B, expected=4'b0110 -> done at t+5; table_out=4'b0110; mismatch=0.
REQ-035 Bench SHALL check back-to-back sweeps: start held high -> second busy rises the cycle after IDLE is re-entered; second done at t+67; mismatch and fail_idx clear at the second start.

Source files
------------

// File: rtl/truth_table_sequencer.sv
// Steps a combinational function through every input combination, holding each
// for DWELL cycles, captures its output into a truth table and compares it to a golden table.
module truth_table_sequencer #(
    parameter int N_IN  = 3,
    parameter int DWELL = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [(1<<N_IN)-1:0]   expected,
    output logic [N_IN-1:0]        dut_in,
    input  logic                   dut_out,
    output logic                   busy,
    output logic                   done,
    output logic [(1<<N_IN)-1:0]   table_out,
    output logic                   mismatch,
    output logic [N_IN-1:0]        fail_idx
);

    localparam int              N_COMB   = 1 << N_IN;
    localparam logic [N_IN-1:0] LAST_IN  = {N_IN{1'b1}};
    localparam logic [7:0]      DWELL_M1 = 8'(DWELL - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

    state_t              state_q, state_d;
    logic [N_IN-1:0]     dut_in_q, dut_in_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [N_COMB-1:0]   table_q, table_d;
    logic [N_COMB-1:0]   exp_q, exp_d;
    logic                mismatch_q, mismatch_d;
    logic [N_IN-1:0]     fail_idx_q, fail_idx_d;
    logic [N_COMB-1:0]   diff;
    logic [N_IN-1:0]     first_diff;

    // Priority encoder: scanning downwards leaves the lowest differing index.
    always_comb begin
        diff       = table_q ^ exp_q;
        first_diff = '0;
        for (int k = N_COMB - 1; k >= 0; k--) begin
            if (diff[k]) first_diff = N_IN'(k);
        end
    end

    always_comb begin
        state_d    = state_q;
        dut_in_d   = dut_in_q;
        cnt_d      = cnt_q;
        table_d    = table_q;
        exp_d      = exp_q;
        mismatch_d = mismatch_q;
        fail_idx_d = fail_idx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = DRIVE;
                    dut_in_d   = '0;
                    cnt_d      = '0;
                    table_d    = '0;
                    exp_d      = expected;
                    mismatch_d = 1'b0;
                    fail_idx_d = '0;
                end
            end
            DRIVE: begin
                if (cnt_q == DWELL_M1) begin
                    table_d[dut_in_q] = dut_out;
                    cnt_d             = '0;
                    if (dut_in_q == LAST_IN) begin
                        state_d  = DONE;
                        dut_in_d = '0;
                    end else begin
                        dut_in_d = dut_in_q + N_IN'(1);
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                mismatch_d = |diff;
                fail_idx_d = first_diff;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            dut_in_q   <= '0;
            cnt_q      <= '0;
            table_q    <= '0;
            exp_q      <= '0;
            mismatch_q <= 1'b0;
            fail_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            dut_in_q   <= dut_in_d;
            cnt_q      <= cnt_d;
            table_q    <= table_d;
            exp_q      <= exp_d;
            mismatch_q <= mismatch_d;
            fail_idx_q <= fail_idx_d;
        end
    end

    assign dut_in    = dut_in_q;
    assign busy      = (state_q == DRIVE);
    assign done      = (state_q == DONE);
    assign table_out = table_q;
    assign mismatch  = mismatch_q;
    assign fail_idx  = fail_idx_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Scoreboard bench: stimulus pushes expected sweep results, a monitor pops them on each done pulse.
module tb_truth_table_sequencer;

    typedef struct {
        logic [7:0] tbl;
        logic       mm;
        logic [2:0] idx;
        int         at;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    // Instance A: defaults, F = (A&B)|C (optionally inverted)
    logic       start_a = 1'b0;
    logic [7:0] exp_a = 8'h00;
    logic [2:0] din_a;
    logic       dout_a;
    logic       busy_a, done_a, mm_a;
    logic [7:0] tbl_a;
    logic [2:0] fidx_a;
    logic       model_inv = 1'b0;

    // Instance B: N_IN=2, DWELL=1, F = A^B
    logic       start_b = 1'b0;
    logic [3:0] exp_b = 4'h0;
    logic [1:0] din_b;
    logic       dout_b;
    logic       busy_b, done_b, mm_b;
    logic [3:0] tbl_b;
    logic [1:0] fidx_b;

    exp_t q_a[$];
    exp_t q_b[$];

    assign dout_a = ((din_a[0] & din_a[1]) | din_a[2]) ^ model_inv;
    assign dout_b = din_b[0] ^ din_b[1];

    truth_table_sequencer #(.N_IN(3), .DWELL(4)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .expected(exp_a),
        .dut_in(din_a), .dut_out(dout_a), .busy(busy_a), .done(done_a),
        .table_out(tbl_a), .mismatch(mm_a), .fail_idx(fidx_a)
    );

    truth_table_sequencer #(.N_IN(2), .DWELL(1)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .expected(exp_b),
        .dut_in(din_b), .dut_out(dout_b), .busy(busy_b), .done(done_b),
        .table_out(tbl_b), .mismatch(mm_b), .fail_idx(fidx_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: one transaction per done pulse; result flags checked the following cycle.
    exp_t cur_a, cur_b;
    logic pend_a = 1'b0, pend_b = 1'b0;
    always @(negedge clk) begin
        if (pend_a) begin
            chk("A mismatch", 32'(mm_a), 32'(cur_a.mm));
            chk("A fail_idx", 32'(fidx_a), 32'(cur_a.idx));
            pend_a = 1'b0;
        end
        if (pend_b) begin
            chk("B mismatch", 32'(mm_b), 32'(cur_b.mm));
            chk("B fail_idx", 32'(fidx_b), 32'(cur_b.idx));
            pend_b = 1'b0;
        end
        if (done_a) begin
            if (q_a.size() == 0) begin
                chk("A unexpected done", 32'(1), 32'(0));
            end else begin
                cur_a = q_a.pop_front();
                $display("A sweep done at cycle %0d table %02h", cyc, tbl_a);
                chk("A done cycle", 32'(cyc), 32'(cur_a.at));
                chk("A table_out", 32'(tbl_a), 32'(cur_a.tbl));
                chk("A busy in done", 32'(busy_a), 32'(0));
                pend_a = 1'b1;
            end
        end
        if (done_b) begin
            if (q_b.size() == 0) begin
                chk("B unexpected done", 32'(1), 32'(0));
            end else begin
                cur_b = q_b.pop_front();
                $display("B sweep done at cycle %0d table %01h", cyc, tbl_b);
                chk("B done cycle", 32'(cyc), 32'(cur_b.at));
                chk("B table_out", 32'({4'h0, tbl_b}), 32'(cur_b.tbl));
                chk("B busy in done", 32'(busy_b), 32'(0));
                pend_b = 1'b1;
            end
        end
    end

    task automatic launch_a(output int t);
        start_a = 1'b1;
        @(posedge clk);
        #1 t = cyc;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        // Reset with start asserted: start must be ignored.
        start_a = 1'b1;
        repeat (3) @(negedge clk);
        start_a = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset busy", 32'(busy_a), 32'(0));
        chk("reset done", 32'(done_a), 32'(0));
        chk("reset dut_in", 32'(din_a), 32'(0));
        chk("reset table_out", 32'(tbl_a), 32'(0));
        chk("reset mismatch", 32'(mm_a), 32'(0));
        chk("reset fail_idx", 32'(fidx_a), 32'(0));

        // Full sweep, golden F8; expected changed mid-sweep has no effect.
        exp_a = 8'hF8;
        launch_a(t);
        q_a.push_back('{tbl: 8'hF8, mm: 1'b0, idx: 3'd0, at: t + 32});
        exp_a = 8'h00;
        chk("sweep busy rise", 32'(busy_a), 32'(1));
        for (int k = 0; k < 32; k++) begin
            chk("sweep dut_in", 32'(din_a), 32'(k / 4));
            @(negedge clk);
        end
        chk("dut_in wrap", 32'(din_a), 32'(0));
        repeat (3) @(negedge clk);

        // Mismatch detection: golden F0 vs captured F8 -> index 3.
        exp_a = 8'hF0;
        launch_a(t);
        q_a.push_back('{tbl: 8'hF8, mm: 1'b1, idx: 3'd3, at: t + 32});
        repeat (36) @(negedge clk);
        chk("idle hold table", 32'(tbl_a), 32'hF8);
        chk("idle hold mismatch", 32'(mm_a), 32'(1));
        chk("idle hold fail_idx", 32'(fidx_a), 32'(3));

        // Reset mid-sweep with inverted model, so table is non-zero before reset.
        model_inv = 1'b1;
        exp_a = 8'hF8;
        launch_a(t);
        chk("start clears mismatch", 32'(mm_a), 32'(0));
        chk("start clears fail_idx", 32'(fidx_a), 32'(0));
        repeat (9) @(negedge clk);
        chk("pre-reset table", 32'(tbl_a), 32'h03);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort busy", 32'(busy_a), 32'(0));
        chk("abort dut_in", 32'(din_a), 32'(0));
        chk("abort table_out", 32'(tbl_a), 32'(0));
        model_inv = 1'b0;
        repeat (40) @(negedge clk);

        // Extra starts while busy are ignored.
        exp_a = 8'hF8;
        launch_a(t);
        q_a.push_back('{tbl: 8'hF8, mm: 1'b0, idx: 3'd0, at: t + 32});
        repeat (4) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (14) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (20) @(negedge clk);

        // Back-to-back sweeps with start held high.
        exp_a = 8'hF0;
        start_a = 1'b1;
        @(posedge clk);
        #1 t = cyc;
        q_a.push_back('{tbl: 8'hF8, mm: 1'b1, idx: 3'd3, at: t + 32});
        q_a.push_back('{tbl: 8'hF8, mm: 1'b0, idx: 3'd0, at: t + 66});
        @(negedge clk);
        exp_a = 8'hF8;
        repeat (33) @(negedge clk);
        chk("b2b idle busy", 32'(busy_a), 32'(0));
        chk("b2b idle mismatch", 32'(mm_a), 32'(1));
        @(negedge clk);
        start_a = 1'b0;
        chk("b2b second busy", 32'(busy_a), 32'(1));
        chk("b2b cleared mismatch", 32'(mm_a), 32'(0));
        chk("b2b cleared fail_idx", 32'(fidx_a), 32'(0));
        repeat (36) @(negedge clk);

        // DWELL=1, N_IN=2, F=A^B.
        exp_b = 4'b0110;
        start_b = 1'b1;
        @(posedge clk);
        #1 t = cyc;
        q_b.push_back('{tbl: 8'h06, mm: 1'b0, idx: 3'd0, at: t + 4});
        @(negedge clk);
        start_b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("B dut_in", 32'(din_b), 32'(k));
            chk("B busy", 32'(busy_b), 32'(1));
            @(negedge clk);
        end
        repeat (6) @(negedge clk);

        chk("A scoreboard drained", 32'(q_a.size()), 32'(0));
        chk("B scoreboard drained", 32'(q_b.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
